// File: rtl/lo_nco_if.sv
// Control and sample bundle between the LO NCO and its consumer (mixer side).
// The master drives the control inputs; the slave, the NCO itself, returns LO samples.
interface lo_nco_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned IDX_W = 10,
  parameter int unsigned OUT_W = 11
);
  logic                    enable;
  logic [ACC_W-1:0]        fcw_in;
  logic                    fcw_load;
  logic [IDX_W-1:0]        phase_off;
  logic                    phase_clr;
  logic signed [OUT_W-1:0] demod_Lo_real;
  logic signed [OUT_W-1:0] demod_Lo_imag;
  logic                    lo_valid;

  modport master (
    output enable, fcw_in, fcw_load, phase_off, phase_clr,
    input  demod_Lo_real, demod_Lo_imag, lo_valid
  );

  modport slave (
    input  enable, fcw_in, fcw_load, phase_off, phase_clr,
    output demod_Lo_real, demod_Lo_imag, lo_valid
  );
endinterface

// File: rtl/lo_nco.sv
// Complex LO generator e^{-jwt}: phase accumulator, quarter-wave sine LUT with
// quadrant folding, 3-stage pipeline (index, magnitude/sign, signed output).
module lo_nco #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned IDX_W = 10,
  parameter int unsigned OUT_W = 11
) (
  input  logic    clk480,
  input  logic    reset,
  lo_nco_if.slave lo_if
);

  localparam int unsigned QtrN    = 1 << (IDX_W - 2);
  localparam int unsigned MagW    = OUT_W - 1;
  localparam int unsigned AddrW   = IDX_W - 1;
  localparam int unsigned Amp     = (1 << MagW) - 1;
  localparam int unsigned LutBits = (QtrN + 1) * MagW;
  localparam int unsigned LutIdxW = $clog2(LutBits);
  localparam longint      PiQ30   = 64'sd3373259426;

  // Elaboration-time table Q[k] = round(Amp * sin(pi*k/(2*QtrN))), k = 0..QtrN,
  // evaluated with a Q30 fixed-point Taylor series so no real math reaches synthesis.
  function automatic logic [LutBits-1:0] gen_sin_lut();
    logic [LutBits-1:0] lut;
    longint x, x2, term, s, v;
    lut = '0;
    for (int k = 0; k <= int'(QtrN); k++) begin
      x    = (PiQ30 * longint'(k)) / longint'(2 * QtrN);
      x2   = (x * x) >>> 30;
      term = x;
      s    = x;
      for (int n = 1; n <= 8; n++) begin
        term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
        s    = s + term;
      end
      v = (s * longint'(Amp) + (longint'(1) <<< 29)) >>> 30;
      if (v > longint'(Amp)) v = longint'(Amp);
      if (v < 0) v = 0;
      lut[LutIdxW'(k * int'(MagW)) +: MagW] = MagW'(v);
    end
    return lut;
  endfunction

  localparam logic [LutBits-1:0] SinLut = gen_sin_lut();

  function automatic logic [MagW-1:0] lut_rd(input logic [AddrW-1:0] addr);
    logic [LutIdxW-1:0] base;
    base = LutIdxW'(addr) * LutIdxW'(MagW);
    return SinLut[base +: MagW];
  endfunction

  // Returns {negative, magnitude} of sin(2*pi*idx/2^IDX_W).
  function automatic logic [MagW:0] fold(input logic [IDX_W-1:0] idx);
    logic [AddrW-1:0] a;
    logic [AddrW-1:0] addr;
    a    = {1'b0, idx[IDX_W-3:0]};
    addr = idx[IDX_W-2] ? AddrW'(QtrN) - a : a;
    return {idx[IDX_W-1], lut_rd(addr)};
  endfunction

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ACC_W-1:0]        fcw_q, fcw_d;
  logic [IDX_W-1:0]        idx_s_q, idx_s_d;
  logic [IDX_W-1:0]        idx_c_q, idx_c_d;
  logic [MagW-1:0]         mag_s_q, mag_s_d;
  logic [MagW-1:0]         mag_c_q, mag_c_d;
  logic                    neg_s_q, neg_s_d;
  logic                    neg_c_q, neg_c_d;
  logic signed [OUT_W-1:0] real_q, real_d;
  logic signed [OUT_W-1:0] imag_q, imag_d;
  logic [2:0]              vld_q, vld_d;

  always_comb begin
    fcw_d = lo_if.fcw_load ? lo_if.fcw_in : fcw_q;

    acc_d = acc_q;
    if (lo_if.phase_clr) begin
      acc_d = '0;
    end else if (lo_if.enable) begin
      acc_d = acc_q + fcw_q;
    end

    idx_s_d = acc_q[ACC_W-1 -: IDX_W] + lo_if.phase_off;
    // Cosine is the sine a quarter turn ahead.
    idx_c_d = idx_s_d + IDX_W'(QtrN);

    {neg_s_d, mag_s_d} = fold(idx_s_q);
    {neg_c_d, mag_c_d} = fold(idx_c_q);

    // Magnitude never exceeds Amp, so negation stays in range and -0 is 0.
    real_d = neg_c_q ? -$signed({1'b0, mag_c_q}) : $signed({1'b0, mag_c_q});
    imag_d = neg_s_q ? $signed({1'b0, mag_s_q}) : -$signed({1'b0, mag_s_q});

    vld_d = {vld_q[1:0], 1'b1};
  end

  always_ff @(posedge clk480 or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      fcw_q   <= '0;
      idx_s_q <= '0;
      idx_c_q <= '0;
      mag_s_q <= '0;
      mag_c_q <= '0;
      neg_s_q <= 1'b0;
      neg_c_q <= 1'b0;
      real_q  <= '0;
      imag_q  <= '0;
      vld_q   <= '0;
    end else begin
      fcw_q <= fcw_d;
      acc_q <= acc_d;
      if (lo_if.enable) begin
        idx_s_q <= idx_s_d;
        idx_c_q <= idx_c_d;
        mag_s_q <= mag_s_d;
        mag_c_q <= mag_c_d;
        neg_s_q <= neg_s_d;
        neg_c_q <= neg_c_d;
        real_q  <= real_d;
        imag_q  <= imag_d;
        vld_q   <= vld_d;
      end
    end
  end

  assign lo_if.demod_Lo_real = real_q;
  assign lo_if.demod_Lo_imag = imag_q;
  assign lo_if.lo_valid      = vld_q[2];

endmodule
